// File: rtl/morse_player.sv
// Morse playback transmitter: replays packed 10-bit RAM words (0..length-1) as a timed key signal.
// First mark starts 4 clocks after start; no backpressure, durations advance only on tick strobes.
module morse_player #(
  parameter int ADDR_W         = 4,
  parameter int DOT_TICKS      = 1,
  parameter int DASH_TICKS     = 3,
  parameter int SYM_GAP_TICKS  = 1,
  parameter int WORD_GAP_TICKS = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  input  logic [9:0]        ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              key_out,
  output logic [1:0]        symbol,
  output logic              busy,
  output logic              done
);

  localparam int MARK_MAX = (DASH_TICKS > DOT_TICKS) ? DASH_TICKS : DOT_TICKS;
  localparam int GAP_MAX  = (WORD_GAP_TICKS > SYM_GAP_TICKS) ? WORD_GAP_TICKS : SYM_GAP_TICKS;
  localparam int TICK_MAX = (MARK_MAX > GAP_MAX) ? MARK_MAX : GAP_MAX;
  localparam int CNT_W    = $clog2(TICK_MAX + 1);

  localparam logic [CNT_W-1:0] DOT_CNT  = CNT_W'(DOT_TICKS);
  localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] SGAP_CNT = CNT_W'(SYM_GAP_TICKS);
  localparam logic [CNT_W-1:0] WGAP_CNT = CNT_W'(WORD_GAP_TICKS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SYM,
    S_MARK,
    S_SPACE,
    S_WGAP,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [9:0]        shreg;
  logic [2:0]        sym;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] len;

  logic cnt_expire;
  logic is_mark;
  logic last_word;

  // The counted tick that brings cnt to zero is the one that ends the interval.
  assign cnt_expire = tick && (cnt <= CNT_W'(1));
  // 01 and 11 both carry a 1 in the low bit; 00 and 10 terminate the word.
  assign is_mark    = shreg[8] && (sym != 3'd5);
  assign last_word  = (idx == len - ADDR_W'(1));
  assign ram_addr   = idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (length != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SYM;
      S_SYM:   state_nxt = is_mark ? S_MARK : S_WGAP;
      S_MARK: begin
        if (cnt_expire) state_nxt = S_SPACE;
      end
      S_SPACE: begin
        if (cnt_expire) state_nxt = S_SYM;
      end
      S_WGAP: begin
        if (cnt_expire) state_nxt = last_word ? S_DONE : S_FETCH;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      shreg <= '0;
      sym   <= '0;
      idx   <= '0;
      len   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && (length != '0)) begin
            idx  <= '0;
            len  <= length;
            busy <= 1'b1;
          end
        end
        S_LOAD: begin
          shreg <= ram_q;
          sym   <= '0;
        end
        S_SYM: begin
          if (is_mark) begin
            cnt <= shreg[9] ? DASH_CNT : DOT_CNT;
          end else begin
            cnt <= WGAP_CNT;
          end
        end
        S_MARK: begin
          if (cnt_expire) begin
            cnt <= SGAP_CNT;
          end else if (tick) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SPACE: begin
          if (cnt_expire) begin
            cnt   <= '0;
            shreg <= {shreg[7:0], 2'b00};
            sym   <= sym + 3'd1;
          end else if (tick) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WGAP: begin
          if (cnt_expire) begin
            cnt <= '0;
            if (!last_word) idx <= idx + ADDR_W'(1);
          end else if (tick) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset drops the key in the same cycle.
  always_comb begin
    key_out = 1'b0;
    symbol  = 2'b00;
    done    = 1'b0;
    unique case (state)
      S_MARK: begin
        key_out = 1'b1;
        symbol  = shreg[9:8];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_morse_player.sv
// Bench for morse_player: random words and tick patterns against a per-symbol timeline model.
module tb_morse_player;

  localparam int DOT   = 1;
  localparam int DASH  = 3;
  localparam int SGAP  = 1;
  localparam int WGAPT = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic [3:0] length;
  logic [9:0] ram_q;
  logic [3:0] ram_addr;
  logic       key_out;
  logic [1:0] symbol;
  logic       busy;
  logic       done;

  morse_player #(
    .ADDR_W(4), .DOT_TICKS(DOT), .DASH_TICKS(DASH),
    .SYM_GAP_TICKS(SGAP), .WORD_GAP_TICKS(WGAPT)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .length(length),
    .ram_q(ram_q), .ram_addr(ram_addr), .key_out(key_out), .symbol(symbol),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // RAM with two cycles of read latency: address register, then output register.
  logic [9:0] mem [16];
  logic [3:0] addr_q;
  always @(posedge clock) begin
    addr_q <= ram_addr;
    ram_q  <= mem[addr_q];
  end

  int checks = 0;
  int errors = 0;
  int tick_mode = 0;
  int tcnt = 0;

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (tick_mode)
        1:       tick = 1'b1;
        2:       tick = (tcnt % 4 == 3);
        3:       tick = ($urandom_range(0, 2) == 0);
        default: tick = 1'b0;
      endcase
      tcnt++;
    end
  end

  // Observer: per-cycle trace plus a per-mark (symbol, counted ticks) log.
  bit         mon_en = 1'b0;
  bit         prev_key;
  int         cur_ticks;
  int         glitch;
  bit         obs_key[$];
  logic [1:0] obs_symtr[$];
  bit         obs_done[$];
  logic [1:0] obs_msym[$];
  int         obs_mticks[$];
  int         obs_addr[$];

  always @(negedge clock) begin
    if (mon_en) begin
      obs_key.push_back(key_out);
      obs_symtr.push_back(symbol);
      obs_done.push_back(done);
      if (key_out && !prev_key) begin
        obs_msym.push_back(symbol);
        cur_ticks = 0;
      end
      if (key_out && symbol !== obs_msym[obs_msym.size()-1]) glitch++;
      if (!key_out && symbol !== 2'b00) glitch++;
      if (key_out && tick) cur_ticks++;
      if (!key_out && prev_key) obs_mticks.push_back(cur_ticks);
      if (busy && (obs_addr.size() == 0 || obs_addr[obs_addr.size()-1] != int'(ram_addr)))
        obs_addr.push_back(int'(ram_addr));
      prev_key = key_out;
    end
  end

  // Reference model: expected marks and, for tick tied high, the exact cycle timeline.
  bit         exp_key[$];
  logic [1:0] exp_symtr[$];
  bit         exp_done[$];
  logic [1:0] exp_msym[$];
  int         exp_mticks[$];

  task automatic push_cyc(input bit k, input logic [1:0] s, input bit d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_key.push_back(k);
      exp_symtr.push_back(s);
      exp_done.push_back(d);
    end
  endtask

  task automatic build_model(input int len);
    logic [1:0] code;
    int n;
    exp_key.delete(); exp_symtr.delete(); exp_done.delete();
    exp_msym.delete(); exp_mticks.delete();
    push_cyc(0, 2'b00, 0, 1);                 // idle cycle holding start
    for (int w = 0; w < len; w++) begin
      push_cyc(0, 2'b00, 0, 3);               // fetch, wait, load
      for (int s = 0; s < 5; s++) begin
        code = 2'(mem[w] >> (8 - 2 * s));
        if (code != 2'b01 && code != 2'b11) break;
        n = (code == 2'b11) ? DASH : DOT;
        exp_msym.push_back(code);
        exp_mticks.push_back(n);
        push_cyc(0, 2'b00, 0, 1);
        push_cyc(1, code, 0, n);
        push_cyc(0, 2'b00, 0, SGAP);
      end
      push_cyc(0, 2'b00, 0, 1 + WGAPT);       // terminating decision plus word gap
    end
    push_cyc(0, 2'b00, 1, 1);
    push_cyc(0, 2'b00, 0, 1);
  endtask

  function automatic logic [9:0] rand_word();
    logic [9:0] w;
    int r;
    w = '0;
    for (int s = 0; s < 5; s++) begin
      r = int'($urandom_range(0, 9));
      w = {w[7:0], (r < 4) ? 2'b01 : (r < 8) ? 2'b11 : (r == 8) ? 2'b00 : 2'b10};
    end
    return w;
  endfunction

  task automatic play(input logic [3:0] len, input int inject, output bit to);
    obs_key.delete(); obs_symtr.delete(); obs_done.delete();
    obs_msym.delete(); obs_mticks.delete(); obs_addr.delete();
    glitch = 0; prev_key = 1'b0; cur_ticks = 0;
    @(posedge clock); #1;
    start = 1'b1; length = len; mon_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      if (inject != 0 && k == inject) begin
        start = 1'b1; length = 4'd15;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      if (done) begin
        to = 1'b0;
        break;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #1 mon_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; length = '0; tick_mode = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (key_out !== 1'b0) begin errors++; $display("FAIL reset_key: got %b want 0", key_out); end
    checks++; if (symbol !== 2'b00) begin errors++; $display("FAIL reset_symbol: got %b want 00", symbol); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (ram_addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
    reset = 1'b0;
  endtask

  task automatic test_single_word(input string name, input logic [9:0] w);
    bit to, bad;
    int nd;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = w;
    tick_mode = 2;
    build_model(1);
    play(4'd1, 0, to);
    checks++; if (to) begin errors++; $display("FAIL %s_timeout: no done within budget", name); end
    bad = (obs_msym.size() != exp_msym.size()) || (obs_mticks.size() != exp_mticks.size());
    for (int i = 0; i < exp_msym.size() && !bad; i++)
      if (obs_msym[i] !== exp_msym[i] || obs_mticks[i] != exp_mticks[i]) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL %s_marks: got %0d marks %p ticks %p, want %0d marks %p ticks %p", name, obs_msym.size(), obs_msym, obs_mticks, exp_msym.size(), exp_msym, exp_mticks); end
    checks++; if (obs_addr.size() != 1 || obs_addr[0] != 0) begin errors++; $display("FAIL %s_addr: got %p want {0}", name, obs_addr); end
    nd = 0;
    foreach (obs_done[i]) nd += int'(obs_done[i]);
    checks++; if (nd != 1) begin errors++; $display("FAIL %s_done_count: got %0d want 1", name, nd); end
    checks++; if (busy !== 1'b0 || glitch != 0) begin errors++; $display("FAIL %s_end: busy %b symbol glitches %0d, want 0 and 0", name, busy, glitch); end
  endtask

  task automatic test_tick_high(input string name, input int len);
    bit to, bad;
    int at;
    tick_mode = 1;
    build_model(len);
    play(4'(len), 0, to);
    checks++; if (to) begin errors++; $display("FAIL %s_timeout: no done within budget", name); end
    bad = (obs_key.size() != exp_key.size());
    at = -1;
    for (int i = 0; i < exp_key.size() && i < obs_key.size(); i++)
      if (at < 0 && (obs_key[i] !== exp_key[i] || obs_symtr[i] !== exp_symtr[i] || obs_done[i] !== exp_done[i])) at = i;
    checks++; if (bad || at >= 0) begin errors++; $display("FAIL %s_trace: got %0d cycles, first diff at %0d, want %0d cycles", name, obs_key.size(), at, exp_key.size()); end
    bad = (obs_addr.size() != len);
    for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] != i) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL %s_addr: got %p want 0..%0d", name, obs_addr, len - 1); end
  endtask

  task automatic test_multi_word();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 10'b01_00_00_00_00;
    mem[1] = 10'b00_00_00_00_00;
    mem[2] = 10'b11_10_01_01_01;
    test_tick_high("multi", 3);
    checks++; if (exp_msym.size() != 2 || obs_msym.size() != 2) begin errors++; $display("FAIL multi_count: got %0d marks want 2", obs_msym.size()); end
  endtask

  task automatic test_zero_length();
    test_tick_high("zero_len", 0);
  endtask

  task automatic test_start_while_busy();
    bit to, bad;
    int nd;
    mem[0] = rand_word(); mem[1] = rand_word();
    tick_mode = 3;
    build_model(2);
    play(4'd2, 8, to);
    checks++; if (to) begin errors++; $display("FAIL busy_start_timeout: no done within budget"); end
    checks++; if (obs_addr.size() != 2 || obs_addr[0] != 0 || obs_addr[1] != 1) begin errors++; $display("FAIL busy_start_addr: got %p want {0,1}", obs_addr); end
    nd = 0;
    foreach (obs_done[i]) nd += int'(obs_done[i]);
    bad = (obs_msym.size() != exp_msym.size());
    checks++; if (nd != 1 || bad) begin errors++; $display("FAIL busy_start_once: done pulses %0d marks %0d, want 1 and %0d", nd, obs_msym.size(), exp_msym.size()); end
    length = '0;
  endtask

  task automatic test_tick_high_random();
    int len;
    for (int it = 0; it < 3; it++) begin
      len = int'($urandom_range(1, 15));
      for (int i = 0; i < 16; i++) mem[i] = rand_word();
      test_tick_high("tick_high_rand", len);
    end
  endtask

  task automatic test_back_to_back_random();
    bit to, bad;
    int len, nd;
    for (int it = 0; it < 5; it++) begin
      len = (it == 4) ? 15 : int'($urandom_range(1, 14));
      for (int i = 0; i < 16; i++) mem[i] = rand_word();
      tick_mode = 3;
      build_model(len);
      play(4'(len), 0, to);
      checks++; if (to) begin errors++; $display("FAIL rand_timeout: iteration %0d no done", it); end
      bad = (obs_msym.size() != exp_msym.size()) || (obs_mticks.size() != exp_mticks.size());
      for (int i = 0; i < exp_msym.size() && !bad; i++)
        if (obs_msym[i] !== exp_msym[i] || obs_mticks[i] != exp_mticks[i]) bad = 1'b1;
      checks++; if (bad || glitch != 0) begin errors++; $display("FAIL rand_marks: iteration %0d got %0d marks (glitches %0d) want %0d marks", it, obs_msym.size(), glitch, exp_msym.size()); end
      bad = (obs_addr.size() != len);
      for (int i = 0; i < obs_addr.size(); i++) if (obs_addr[i] != i) bad = 1'b1;
      checks++; if (bad) begin errors++; $display("FAIL rand_addr: iteration %0d got %p want 0..%0d", it, obs_addr, len - 1); end
      nd = 0;
      foreach (obs_done[i]) nd += int'(obs_done[i]);
      checks++; if (nd != 1 || busy !== 1'b0) begin errors++; $display("FAIL rand_done: iteration %0d done pulses %0d busy %b, want 1 and 0", it, nd, busy); end
    end
  endtask

  task automatic test_reset_mid_dash();
    bit seen, rose;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 10'b11_11_11_11_11;
    tick_mode = 2;
    @(posedge clock); #1;
    start = 1'b1; length = 4'd1;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clock);
      if (key_out) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_dash_wait: key_out never rose"); end
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if (key_out !== 1'b0) begin errors++; $display("FAIL mid_dash_key: got %b want 0", key_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_dash_flags: busy %b done %b want 0 0", busy, done); end
    checks++; if (ram_addr !== 4'd0 || symbol !== 2'b00) begin errors++; $display("FAIL mid_dash_addr: addr %0d symbol %b want 0 00", ram_addr, symbol); end
    @(negedge clock);
    reset = 1'b0;
    rose = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (key_out || busy) rose = 1'b1;
    end
    checks++; if (rose) begin errors++; $display("FAIL mid_dash_resume: playback resumed after reset"); end
  endtask

  initial begin
    test_reset();
    test_single_word("word_a", 10'b01_11_00_00_00);
    test_single_word("full_word", 10'b11_11_11_11_11);
    test_multi_word();
    test_zero_length();
    test_start_while_busy();
    test_tick_high_random();
    test_back_to_back_random();
    test_reset_mid_dash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
